gate_truth_sequencer: RTL and testbench

- Self-test controller for a 2-input switch-level gate (cmos_nor class) in the ELC5311 cell library.
- On start, drives every input combination in order onto the gate under test (DUT) and waits a programmable settle time per vector.
- Samples the DUT output and compares it against a parameterised truth table.
- Reports pass/fail, a mismatch count and the first failing vector.
- Replaces hand-written per-gate stimulus blocks with one clocked sequencer shared by all cell benches.

---
 rtl/gate_seq_pkg.sv | 24 ++
 rtl/gate_seq_settle_timer.sv | 27 ++
 rtl/gate_truth_sequencer.sv | 100 ++++++++++
 tb/tb_gate_truth_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/gate_seq_pkg.sv
// Shared types and constants for the gate truth-table sequencer.
// Truth tables index by vector value {x,y}; bit i is the expected output for vector i.
package gate_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] TT_NOR2  = 4'b0001;
  localparam logic [3:0] TT_NAND2 = 4'b0111;
  localparam logic [3:0] TT_AND2  = 4'b1000;
  localparam logic [3:0] TT_OR2   = 4'b1110;
  localparam logic [3:0] TT_XOR2  = 4'b0110;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/gate_seq_settle_timer.sv
// Settle-time down-counter: load has priority over decrement; zero flags an expired hold.
module gate_seq_settle_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/gate_truth_sequencer.sv
// Sweeps every input vector onto a gate, holds each SETTLE_CYCLES+1 cycles, checks against EXPECT_TABLE.
// Optional GATE_SEQ_STOP_ON_FAIL_EN: end the sweep on the first mismatching vector.
module gate_truth_sequencer
  import gate_seq_pkg::*;
#(
  parameter int                  N_IN          = 2,
  parameter int                  SETTLE_CYCLES = 4,
  parameter logic [2**N_IN-1:0]  EXPECT_TABLE  = TT_NOR2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            dut_out,
  output logic [N_IN-1:0] vec_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] fail_vec
);

  localparam int CW_RAW = clog2(SETTLE_CYCLES + 1);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam logic [CW-1:0]   SETTLE_LD = CW'(SETTLE_CYCLES);
  localparam logic [N_IN-1:0] LAST_VEC  = {N_IN{1'b1}};

  state_t        state;
  logic          cnt_zero;
  logic          tmr_load;
  logic          tmr_dec;
  logic          sample;
  logic          mismatch;
  logic          stop_now;
  logic [N_IN:0] err_next;

  always_comb begin
    sample   = (state == ST_RUN) && cnt_zero;
    // 4-state compare so an undriven or contended gate output is caught.
    mismatch = (dut_out !== EXPECT_TABLE[vec_out]);
    err_next = err_count + {{N_IN{1'b0}}, mismatch};
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
    stop_now = sample && (mismatch || (vec_out == LAST_VEC));
`else
    stop_now = sample && (vec_out == LAST_VEC);
`endif
    tmr_load = ((state != ST_RUN) && start) || (sample && !stop_now);
    tmr_dec  = (state == ST_RUN) && !cnt_zero;
  end

  gate_seq_settle_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .dec      (tmr_dec),
    .load_val (SETTLE_LD),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      vec_out   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_vec  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state     <= ST_RUN;
            vec_out   <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_vec  <= '0;
          end
        end
        ST_RUN: begin
          if (sample) begin
            err_count <= err_next;
            if (mismatch && (err_count == '0)) fail_vec <= vec_out;
            if (stop_now) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == '0);
            end else begin
              vec_out <= vec_out + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_truth_sequencer.sv
// Directed bench: gate models driven by vec_out, table of sweeps plus reset/start/settle corner cases.
module tb_gate_truth_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       start0;
  logic       dut_out;
  logic       dut_out0;
  logic [1:0] vec_out;
  logic [1:0] vec_out0;
  logic       busy, done, pass;
  logic       busy0, done0, pass0;
  logic [2:0] err_count, err_count0;
  logic [1:0] fail_vec, fail_vec0;

  int mode;
  int checks;
  int errors;

  gate_truth_sequencer u_dut (
    .clk(clk), .rst(rst), .start(start), .dut_out(dut_out),
    .vec_out(vec_out), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_vec(fail_vec)
  );

  gate_truth_sequencer #(.SETTLE_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .dut_out(dut_out0),
    .vec_out(vec_out0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err_count0), .fail_vec(fail_vec0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gate models: 0 NOR, 1 stuck-at-0, 2 NAND, 3 stuck-at-1, 4 OR. x = vec[1], y = vec[0].
  always_comb begin
    case (mode)
      1:       dut_out = 1'b0;
      2:       dut_out = ~(vec_out[1] & vec_out[0]);
      3:       dut_out = 1'b1;
      4:       dut_out = vec_out[1] | vec_out[0];
      default: dut_out = ~(vec_out[1] | vec_out[0]);
    endcase
  end
  assign dut_out0 = ~(vec_out0[1] | vec_out0[0]);

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_sweep(input int idx, input int mode_i, input int exp_edge, input int exp_err,
                           input int exp_fail, input int exp_pass, input int exp_vec, input bit chk_seq);
    int edge_n;
    string tag;
    tag = $sformatf("sweep%0d", idx);
    edge_n = 0;
    mode = mode_i;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check({tag, "_busy_on_start"}, busy, 1);
    check({tag, "_done_cleared"}, done, 0);
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (done) begin
        edge_n = n;
        break;
      end
      if (chk_seq) check($sformatf("%s_vec_at_edge%0d", tag, n), vec_out, n / 5);
    end
    check({tag, "_done_edge"}, edge_n, exp_edge);
    check({tag, "_err_count"}, err_count, exp_err);
    check({tag, "_fail_vec"}, fail_vec, exp_fail);
    check({tag, "_pass"}, pass, exp_pass);
    check({tag, "_vec_final"}, vec_out, exp_vec);
    check({tag, "_busy_off"}, busy, 0);
  endtask

  typedef struct {
    int mode;
    int edge_n;
    int err;
    int fail;
    int pass;
    int vec;
  } sweep_t;

  sweep_t tbl[5];

  initial begin
    int wait_n;
    checks = 0;
    errors = 0;
    mode   = 0;
    rst    = 1'b1;
    start  = 1'b0;
    start0 = 1'b0;

`ifdef GATE_SEQ_STOP_ON_FAIL_EN
    tbl[0] = '{0, 20, 0, 0, 1, 3};
    tbl[1] = '{1,  5, 1, 0, 0, 0};
    tbl[2] = '{2, 10, 1, 1, 0, 1};
    tbl[3] = '{3, 10, 1, 1, 0, 1};
    tbl[4] = '{4,  5, 1, 0, 0, 0};
`else
    tbl[0] = '{0, 20, 0, 0, 1, 3};
    tbl[1] = '{1, 20, 1, 0, 0, 3};
    tbl[2] = '{2, 20, 2, 1, 0, 3};
    tbl[3] = '{3, 20, 3, 1, 0, 3};
    tbl[4] = '{4, 20, 4, 0, 0, 3};
`endif

    repeat (2) @(negedge clk);
    check("reset_vec", vec_out, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_pass", pass, 0);
    check("reset_err", err_count, 0);
    check("reset_fail", fail_vec, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_no_start_busy", busy, 0);

    for (int i = 0; i < 5; i++)
      run_sweep(i, tbl[i].mode, tbl[i].edge_n, tbl[i].err, tbl[i].fail, tbl[i].pass, tbl[i].vec, tbl[i].mode == 0);

    // Async reset mid-sweep after a mismatch has already been counted.
    mode = 1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_n = 0;
    while (vec_out != 2'd2 && wait_n < 40) begin
      @(negedge clk);
      wait_n++;
    end
    check("rst_mid_reached_vec2", vec_out, 2);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_vec", vec_out, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_err", err_count, 0);
    check("rst_mid_fail", fail_vec, 0);
    check("rst_mid_done", done, 0);
    @(negedge clk) rst = 1'b0;
    run_sweep(10, 0, 20, 0, 0, 1, 3, 1'b1);

    // start held high through RUN must not restart the sweep.
    mode = 1;
    @(negedge clk) start = 1'b1;
    repeat (10) @(negedge clk);
    check("held_start_vec", vec_out, 1);
    check("held_start_busy", busy, 1);
    start = 1'b0;
    wait_n = 0;
    while (!done && wait_n < 40) begin
      @(negedge clk);
      wait_n++;
    end
    check("held_start_done", done, 1);
    check("held_start_err", err_count, 1);
    mode = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("restart_done_clr", done, 0);
    check("restart_err_clr", err_count, 0);
    check("restart_busy", busy, 1);
    check("restart_vec", vec_out, 0);
    wait_n = 0;
    while (!done && wait_n < 40) begin
      @(negedge clk);
      wait_n++;
    end
    check("restart_pass", pass, 1);

    // Zero settle time: one cycle per vector, done on the 4th edge.
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    check("s0_start_vec", vec_out0, 0);
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      check($sformatf("s0_vec_edge%0d", n), vec_out0, (n < 3) ? n : 3);
      check($sformatf("s0_done_edge%0d", n), done0, (n == 4) ? 1 : 0);
    end
    check("s0_pass", pass0, 1);
    check("s0_err", err_count0, 0);
    check("s0_fail", fail_vec0, 0);
    check("s0_busy", busy0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
